// File: rtl/uart_rx.sv
// UART receiver: oversampled start detection, 2-of-3 mid-bit majority vote,
// optional even/odd parity, stop-bit check and a one-cycle DATA_VALID strobe.
module uart_rx #(
  parameter int unsigned DATA_LENGTH = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   RX_IN,
  input  logic [5:0]             PRESCALE,
  input  logic                   PAR_EN,
  input  logic                   PAR_TYP,
  output logic [DATA_LENGTH-1:0] P_DATA,
  output logic                   DATA_VALID,
  output logic                   PAR_ERR,
  output logic                   STP_ERR
);

  localparam int unsigned BW = $clog2(DATA_LENGTH) + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state_q, state_d;
  logic [5:0]             edge_cnt_q, edge_cnt_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [5:0]             prescale_q, prescale_d;
  logic                   par_en_q, par_en_d;
  logic                   par_typ_q, par_typ_d;
  logic [2:0]             samp_q, samp_d;
  logic [DATA_LENGTH-1:0] shift_q, shift_d;
  logic [DATA_LENGTH-1:0] p_data_q, p_data_d;
  logic                   data_valid_q, data_valid_d;
  logic                   par_err_q, par_err_d;
  logic                   stp_err_q, stp_err_d;
  logic                   armed_q, armed_d;

  logic [5:0] half;
  logic       last_edge;
  logic       vote;
  logic       exp_par;

  always_comb begin
    state_d      = state_q;
    edge_cnt_d   = edge_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    prescale_d   = prescale_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    samp_d       = samp_q;
    shift_d      = shift_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
    par_err_d    = par_err_q;
    stp_err_d    = stp_err_q;
    // Only a line seen high since reset may start a frame, so a low line at
    // reset release is not mistaken for a start bit.
    armed_d      = armed_q | RX_IN;

    half      = {1'b0, prescale_q[5:1]};
    last_edge = (edge_cnt_q == prescale_q - 6'd1);
    vote      = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
    exp_par   = par_typ_q ? ~^shift_q : ^shift_q;

    if (state_q != IDLE) begin
      edge_cnt_d = last_edge ? '0 : edge_cnt_q + 6'd1;
      if (edge_cnt_q == half - 6'd1) samp_d[0] = RX_IN;
      if (edge_cnt_q == half)        samp_d[1] = RX_IN;
      if (edge_cnt_q == half + 6'd1) samp_d[2] = RX_IN;
    end

    case (state_q)
      IDLE: begin
        edge_cnt_d = '0;
        if (armed_q && !RX_IN) begin
          // The detection cycle is edge 0 of the start bit.
          state_d    = START;
          edge_cnt_d = 6'd1;
          prescale_d = PRESCALE;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
        end
      end
      START: begin
        if (last_edge) begin
          if (vote) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_cnt_d = '0;
            par_err_d = 1'b0;
            stp_err_d = 1'b0;
          end
        end
      end
      DATA: begin
        if (last_edge) begin
          shift_d                = shift_q >> 1;
          shift_d[DATA_LENGTH-1] = vote;
          if (bit_cnt_q == BW'(DATA_LENGTH - 1)) begin
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (last_edge) begin
          par_err_d = (vote != exp_par);
          state_d   = STOP;
        end
      end
      STOP: begin
        if (last_edge) begin
          stp_err_d = ~vote;
          state_d   = IDLE;
          if (vote && !par_err_q) begin
            p_data_d     = shift_q;
            data_valid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      edge_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      prescale_q   <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      samp_q       <= '1;
      shift_q      <= '0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      edge_cnt_q   <= edge_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      prescale_q   <= prescale_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      samp_q       <= samp_d;
      shift_q      <= shift_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
      armed_q      <= armed_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign DATA_VALID = data_valid_q;
  assign PAR_ERR    = par_err_q;
  assign STP_ERR    = stp_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames driven bit-by-bit at the falling clock
// edge, outputs sampled on falling edges against hand-computed values.
module tb_uart_rx;

  logic       CLK;
  logic       RST;
  logic       RX_IN;
  logic [5:0] PRESCALE;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_ERR;
  logic       STP_ERR;

  int checks   = 0;
  int errors   = 0;
  int dv_count = 0;

  logic       dv_before;
  logic [1:0] flags_mid;

  uart_rx #(.DATA_LENGTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PRESCALE   (PRESCALE),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_ERR    (PAR_ERR),
    .STP_ERR    (STP_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) if (DATA_VALID === 1'b1) dv_count <= dv_count + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives nbits bit periods of a frame (start, data LSB first, parity, stop),
  // returning at the falling edge just after the last bit period.
  task automatic send_frame(input logic [7:0] data, input int p, input logic pen,
                            input logic ptyp, input logic pbit, input logic sbit,
                            input int nbits, input bit scramble,
                            output logic dv_b, output logic [1:0] fmid);
    logic fb[11];
    int   total;
    fb[0] = 1'b0;
    for (int j = 0; j < 8; j++) fb[j+1] = data[j];
    total = 9;
    if (pen) begin
      fb[total] = pbit;
      total = total + 1;
    end
    fb[total] = sbit;
    total = total + 1;
    PRESCALE = 6'(p);
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    dv_b     = 1'b0;
    fmid     = 2'b11;
    for (int i = 0; i < total && i < nbits; i++) begin
      RX_IN = fb[i];
      for (int k = 0; k < p; k++) begin
        if (scramble && i == 3 && k == 0) begin
          PRESCALE = (p == 8) ? 6'd16 : 6'd8;
          PAR_EN   = ~pen;
          PAR_TYP  = ~ptyp;
        end
        if (i == 2 && k == 0) fmid = {PAR_ERR, STP_ERR};
        if (i == total - 1 && k == p - 1) dv_b = DATA_VALID;
        @(negedge CLK);
      end
    end
  endtask

  initial begin
    RST = 1'b0; RX_IN = 1'b1; PRESCALE = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_p_data", 32'(P_DATA), 32'h00);
    check("rst_dv",     32'(DATA_VALID), 32'h0);
    check("rst_par",    32'(PAR_ERR), 32'h0);
    check("rst_stp",    32'(STP_ERR), 32'h0);
    RST = 1'b1;
    repeat (4) @(negedge CLK);

    // PRESCALE=8, no parity, 0x7D: 80 cycles to the strobe
    send_frame(8'h7D, 8, 1'b0, 1'b0, 1'b0, 1'b1, 99, 1'b0, dv_before, flags_mid);
    check("f7d_dv_early", 32'(dv_before), 32'h0);
    check("f7d_dv",       32'(DATA_VALID), 32'h1);
    check("f7d_data",     32'(P_DATA), 32'h7D);
    check("f7d_par",      32'(PAR_ERR), 32'h0);
    check("f7d_stp",      32'(STP_ERR), 32'h0);
    repeat (5) @(negedge CLK);
    check("f7d_pulses", 32'(dv_count), 32'd1);

    // PRESCALE=16, even parity, 0xAD + parity 1; config inputs change mid-frame
    send_frame(8'hAD, 16, 1'b1, 1'b0, 1'b1, 1'b1, 99, 1'b1, dv_before, flags_mid);
    check("fad_dv_early", 32'(dv_before), 32'h0);
    check("fad_dv",       32'(DATA_VALID), 32'h1);
    check("fad_data",     32'(P_DATA), 32'hAD);
    check("fad_par",      32'(PAR_ERR), 32'h0);
    check("fad_stp",      32'(STP_ERR), 32'h0);
    repeat (5) @(negedge CLK);
    check("fad_pulses", 32'(dv_count), 32'd2);

    // PRESCALE=32, odd parity, 0x57 with wrong parity bit 1
    send_frame(8'h57, 32, 1'b1, 1'b1, 1'b1, 1'b1, 99, 1'b0, dv_before, flags_mid);
    check("f57_dv",   32'(DATA_VALID), 32'h0);
    check("f57_par",  32'(PAR_ERR), 32'h1);
    check("f57_stp",  32'(STP_ERR), 32'h0);
    check("f57_data", 32'(P_DATA), 32'hAD);
    repeat (5) @(negedge CLK);
    check("f57_pulses", 32'(dv_count), 32'd2);

    // PRESCALE=8, stop bit low, then good 0xBB clears both flags
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 99, 1'b0, dv_before, flags_mid);
    RX_IN = 1'b1;
    check("f3c_dv",   32'(DATA_VALID), 32'h0);
    check("f3c_stp",  32'(STP_ERR), 32'h1);
    check("f3c_par",  32'(PAR_ERR), 32'h0);
    check("f3c_data", 32'(P_DATA), 32'hAD);
    repeat (3) @(negedge CLK);
    send_frame(8'hBB, 8, 1'b0, 1'b0, 1'b0, 1'b1, 99, 1'b0, dv_before, flags_mid);
    check("fbb_flags_mid", 32'(flags_mid), 32'h0);
    check("fbb_dv",        32'(DATA_VALID), 32'h1);
    check("fbb_data",      32'(P_DATA), 32'hBB);
    check("fbb_stp",       32'(STP_ERR), 32'h0);
    repeat (5) @(negedge CLK);
    check("fbb_pulses", 32'(dv_count), 32'd3);

    // PRESCALE=16 glitch: 3 low cycles is rejected as a start bit
    PRESCALE = 6'd16;
    RX_IN = 1'b0;
    repeat (3) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (20) @(negedge CLK);
    check("glitch_pulses", 32'(dv_count), 32'd3);
    check("glitch_data",   32'(P_DATA), 32'hBB);
    check("glitch_flags",  32'({PAR_ERR, STP_ERR}), 32'h0);

    // Back-to-back frames with no idle gap
    send_frame(8'h59, 16, 1'b0, 1'b0, 1'b0, 1'b1, 99, 1'b0, dv_before, flags_mid);
    check("b2b1_dv",   32'(DATA_VALID), 32'h1);
    check("b2b1_data", 32'(P_DATA), 32'h59);
    send_frame(8'hBA, 16, 1'b0, 1'b0, 1'b0, 1'b1, 99, 1'b0, dv_before, flags_mid);
    check("b2b2_dv",   32'(DATA_VALID), 32'h1);
    check("b2b2_data", 32'(P_DATA), 32'hBA);
    repeat (5) @(negedge CLK);
    check("b2b_pulses", 32'(dv_count), 32'd5);

    // Reset in the middle of data bit 4, then a clean 0xA5 frame
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 5, 1'b0, dv_before, flags_mid);
    RX_IN = 1'b0;
    repeat (4) @(negedge CLK);
    RST = 1'b0;
    RX_IN = 1'b1;
    #1;
    check("mrst_data",  32'(P_DATA), 32'h00);
    check("mrst_dv",    32'(DATA_VALID), 32'h0);
    check("mrst_flags", 32'({PAR_ERR, STP_ERR}), 32'h0);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (4) @(negedge CLK);
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 99, 1'b0, dv_before, flags_mid);
    check("fa5_dv_early", 32'(dv_before), 32'h0);
    check("fa5_dv",       32'(DATA_VALID), 32'h1);
    check("fa5_data",     32'(P_DATA), 32'hA5);
    check("fa5_flags",    32'({PAR_ERR, STP_ERR}), 32'h0);
    repeat (5) @(negedge CLK);
    check("fa5_pulses", 32'(dv_count), 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_LENGTH, default 8, the number of data bits per frame.
REQ-002 SHALL have CLK  input  1  oversampling clock; one clock, all state on its rising edge.
REQ-003 SHALL have RST  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have RX_IN  input  1  serial line; idle high, frames as produced by TOP_TX.
REQ-005 SHALL have PRESCALE  input  6  oversampling ratio; only 8, 16 and 32 are in contract.
REQ-006 SHALL have PAR_EN  input  1  1 = parity bit present between data and stop.
REQ-007 SHALL have PAR_TYP  input  1  0 = even, 1 = odd.
REQ-008 SHALL have P_DATA  output  DATA_LENGTH  last correctly received data word.
REQ-009 SHALL have DATA_VALID  output  1  one-cycle pulse marking a new error-free word on P_DATA.
REQ-010 SHALL have PAR_ERR  output  1  parity mismatch flag for the most recent frame.
REQ-011 SHALL have STP_ERR  output  1  stop-bit-low flag for the most recent frame.

Function
REQ-012 SHALL receive frames as: start (0), DATA_LENGTH data bits LSB first, optional parity bit, one stop bit (1).
REQ-013 SHALL capture PRESCALE, PAR_EN and PAR_TYP at start detection and hold them for the whole frame.
REQ-014 SHALL use an edge counter 0..PRESCALE-1 per bit period and a bit counter for the data bits.
REQ-015 SHALL decide each bit by a 2-of-3 majority vote of RX_IN samples taken at edge counts PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1.
REQ-016 SHALL implement the states IDLE, START, DATA, PARITY and STOP.
REQ-017 SHALL move IDLE->START on the first cycle with RX_IN=0 and edge counter at 0.
REQ-018 SHALL return START->IDLE at edge PRESCALE-1 if the voted start bit is 1 (glitch), and SHALL raise no output.
REQ-019 SHALL otherwise go START->DATA at edge PRESCALE-1.
REQ-020 SHALL go DATA->PARITY (PAR_EN=1) or DATA->STOP (PAR_EN=0) at edge PRESCALE-1 of data bit DATA_LENGTH-1.
REQ-021 SHALL go PARITY->STOP at edge PRESCALE-1, and STOP->IDLE at edge PRESCALE-1.
REQ-022 SHALL define the expected parity bit as ^data for even and ~^data for odd, matching TOP_TX.
REQ-023 SHALL set PAR_ERR at the end of PARITY when the voted parity bit differs from the expected bit.
REQ-024 SHALL set STP_ERR at the end of STOP when the voted stop bit is 0.
REQ-025 SHALL hold PAR_ERR and STP_ERR until the next valid start-bit entry to DATA, which clears both.
REQ-026 SHALL, on the STOP->IDLE transition with no errors, load P_DATA and pulse DATA_VALID high for exactly one cycle.
REQ-027 SHALL leave P_DATA unchanged and keep DATA_VALID low after any errored frame.
REQ-028 SHALL accept back-to-back frames, i.e. a start bit on the cycle immediately after STOP->IDLE, with no lost frame.
REQ-029 SHALL span (10 + PAR_EN) x PRESCALE cycles per frame from start detection to the DATA_VALID cycle, with DATA_LENGTH=8.
REQ-030 SHALL ignore changes to PRESCALE, PAR_EN and PAR_TYP made mid-frame.

Reset
REQ-031 SHALL, on RST=0 and at any time including mid-frame, immediately force IDLE and clear both counters.
REQ-032 SHALL, on reset, drive P_DATA=0, DATA_VALID=0, PAR_ERR=0 and STP_ERR=0.
REQ-033 SHALL start reception after RST deassertion only on a fresh falling level of RX_IN in IDLE.

Verification
REQ-034 SHALL cover: PRESCALE=8, PAR_EN=0, frame 0x7D -> one DATA_VALID pulse 80 cycles after start, P_DATA=0x7D, both error flags 0.
REQ-035 SHALL cover: PRESCALE=16, even parity, 0xAD with parity bit 1 -> P_DATA=0xAD, DATA_VALID pulse at 176 cycles, PAR_ERR=0.
REQ-036 SHALL cover: PRESCALE=32, odd parity, 0x57 with parity bit 1 (correct bit is 0) -> PAR_ERR=1, no DATA_VALID, P_DATA keeps its prior value.
REQ-037 SHALL cover: PRESCALE=8, stop bit driven 0 -> STP_ERR=1 and no pulse; a following good frame 0xBB -> both flags cleared, then a DATA_VALID pulse with 0xBB.
REQ-038 SHALL cover: PRESCALE=16, RX_IN low for 3 cycles then high -> return to IDLE, no outputs change; then two back-to-back frames 0x59 and 0xBA -> two pulses in order.
REQ-039 SHALL cover: RST=0 asserted during data bit 4 -> all outputs 0 immediately; the next full frame 0xA5 -> received correctly.
